// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - loads a checksummed boot image from SD into instruction memory
// Ports:
//   boot_clk_i, boot_rst_i                    clock, synchronous active-high reset
//   boot_start_i, boot_base_addr_i            start pulse, SD byte address of the image header
//   sd_address_o, sd_re_o                     word read request to the SD read controller
//   sd_data_i, sd_valid_i                     word returned by the SD read controller
//   imem_addr_o, imem_data_o, imem_we_o       instruction-memory write port
//   cpu_rst_o                                 processor reset, released only after a good load
//   boot_busy_o, boot_done_o, boot_error_o    load status (done/error sticky)
//   boot_errcode_o                            failure cause
module boot_loader #(
   parameter int          IMEM_AW        = 14,
   parameter int          TIMEOUT_CYCLES = 1000000,
   parameter logic [15:0] BOOT_MAGIC     = 16'hB007
) (
   input  logic               boot_clk_i,
   input  logic               boot_rst_i,
   input  logic               boot_start_i,
   input  logic [31:0]        boot_base_addr_i,
   output logic [31:0]        sd_address_o,
   output logic               sd_re_o,
   input  logic [31:0]        sd_data_i,
   input  logic               sd_valid_i,
   output logic [IMEM_AW-1:0] imem_addr_o,
   output logic [31:0]        imem_data_o,
   output logic               imem_we_o,
   output logic               cpu_rst_o,
   output logic               boot_busy_o,
   output logic               boot_done_o,
   output logic               boot_error_o,
   output logic [2:0]         boot_errcode_o
);

   // Counter width holds 2^IMEM_AW, the largest legal payload length.
   localparam int          CW    = IMEM_AW + 1;
   localparam logic [31:0] MAX_N = 32'd1 << IMEM_AW;
   localparam logic [31:0] TMO   = 32'(TIMEOUT_CYCLES);

   localparam logic [2:0] ERR_MAGIC   = 3'b001;
   localparam logic [2:0] ERR_LEN     = 3'b010;
   localparam logic [2:0] ERR_TIMEOUT = 3'b011;
   localparam logic [2:0] ERR_CSUM    = 3'b100;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE, S_DONE, S_ERROR} state_t;
   typedef enum logic [1:0] {PH_HEADER, PH_PAYLOAD, PH_CHECKSUM} phase_t;

   state_t        state_q, state_d;
   phase_t        phase_q;
   logic [31:0]   addr_q;
   logic [31:0]   sum_q;
   logic [31:0]   data_q;
   logic [31:0]   tcnt_q;
   logic [CW-1:0] wcnt_q;
   logic [CW-1:0] nwords_q;
   logic [2:0]    errcode_q;
   logic [2:0]    err_d;
   logic          magic_bad;
   logic          len_bad;
   logic          tmo_hit;
   logic          can_start;

   assign magic_bad = sd_data_i[31:16] != BOOT_MAGIC;
   assign len_bad   = (sd_data_i[15:0] == 16'd0) || ({16'd0, sd_data_i[15:0]} > MAX_N);
   // Fires on the WAIT cycle whose end makes the count reach TIMEOUT_CYCLES.
   assign tmo_hit   = (tcnt_q + 32'd1) >= TMO;
   // A start while a load is running is dropped.
   assign can_start = boot_start_i &&
                      (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);

   always_ff @(posedge boot_clk_i) begin
      if (boot_rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      err_d   = 3'b000;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (can_start) state_d = S_REQ;
         end
         S_REQ: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A valid word beats a timeout landing on the same cycle.
            if (sd_valid_i) begin
               case (phase_q)
                  PH_HEADER: begin
                     if (magic_bad) begin
                        state_d = S_ERROR;
                        err_d   = ERR_MAGIC;
                     end else if (len_bad) begin
                        state_d = S_ERROR;
                        err_d   = ERR_LEN;
                     end else begin
                        state_d = S_REQ;
                     end
                  end
                  PH_PAYLOAD: begin
                     state_d = S_WRITE;
                  end
                  default: begin
                     if (sd_data_i == sum_q) begin
                        state_d = S_DONE;
                     end else begin
                        state_d = S_ERROR;
                        err_d   = ERR_CSUM;
                     end
                  end
               endcase
            end else if (tmo_hit) begin
               state_d = S_ERROR;
               err_d   = ERR_TIMEOUT;
            end
         end
         S_WRITE: begin
            state_d = S_REQ;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge boot_clk_i) begin
      if (boot_rst_i) begin
         phase_q   <= PH_HEADER;
         addr_q    <= 32'd0;
         sum_q     <= 32'd0;
         data_q    <= 32'd0;
         tcnt_q    <= 32'd0;
         wcnt_q    <= '0;
         nwords_q  <= '0;
         errcode_q <= 3'b000;
      end else begin
         if (can_start) begin
            phase_q   <= PH_HEADER;
            addr_q    <= boot_base_addr_i;
            sum_q     <= 32'd0;
            wcnt_q    <= '0;
            errcode_q <= 3'b000;
         end
         case (state_q)
            S_REQ: begin
               tcnt_q <= 32'd0;
            end
            S_WAIT: begin
               tcnt_q <= tcnt_q + 32'd1;
               if (state_d == S_ERROR) errcode_q <= err_d;
               if (sd_valid_i) begin
                  data_q <= sd_data_i;
                  // Address only advances on an accepted header, so it stays
                  // stable on the SD side for the whole request.
                  if (phase_q == PH_HEADER && state_d == S_REQ) begin
                     nwords_q <= CW'(sd_data_i[15:0]);
                     addr_q   <= addr_q + 32'd4;
                     phase_q  <= PH_PAYLOAD;
                  end
               end
            end
            S_WRITE: begin
               sum_q  <= sum_q + data_q;
               wcnt_q <= wcnt_q + CW'(1);
               addr_q <= addr_q + 32'd4;
               if (wcnt_q + CW'(1) == nwords_q) phase_q <= PH_CHECKSUM;
            end
            default: begin
            end
         endcase
      end
   end

   assign sd_address_o   = addr_q;
   assign sd_re_o        = (state_q == S_REQ);
   assign imem_addr_o    = wcnt_q[IMEM_AW-1:0];
   assign imem_data_o    = data_q;
   assign imem_we_o      = (state_q == S_WRITE);
   assign cpu_rst_o      = (state_q != S_DONE);
   assign boot_busy_o    = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_WRITE);
   assign boot_done_o    = (state_q == S_DONE);
   assign boot_error_o   = (state_q == S_ERROR);
   assign boot_errcode_o = errcode_q;

endmodule
